acq_sequencer: RTL

Acquisition sequencer for the buffer controller. It accepts a capture request and fills a circular sample buffer with a programmed number of pre-trigger samples. It then arms the edge detector, waits for its `triggered` pulse (or a forced or automatic trigger), and writes the remaining post-trigger samples. It generates the buffer write strobe and address, the edge detector reset, and status flags for the host-side register block.

---
 rtl/acq_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, armed wait and post-trigger fill of a circular sample buffer.
// Define AUTO_TRIGGER_EN to build the auto-trigger timeout counter; otherwise auto_fired is tied low.

module acq_sequencer #(
    parameter int ADDR_BITS    = 12,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_BITS-1:0]    num_samples,
    input  logic [ADDR_BITS-1:0]    pretrigger,
    input  logic [TIMEOUT_BITS-1:0] auto_timeout,
    input  logic                    input_rdy,
    input  logic                    triggered,
    input  logic                    force_trigger,
    output logic                    det_rst,
    output logic                    wr_en,
    output logic [ADDR_BITS-1:0]    wr_addr,
    output logic [ADDR_BITS-1:0]    trig_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    auto_fired
);

    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [CW-1:0] ONE   = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST_FILL, DONE} state_t;

    state_t state, next_state;

    logic [CW-1:0]        n_eff, p_eff, post_init;
    logic [CW-1:0]        p_lat, post_lat, pre_cnt, post_cnt;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 start_ok, trig_any, auto_hit, do_write;

    always_comb begin
        n_eff     = (num_samples == '0) ? DEPTH : {1'b0, num_samples};
        p_eff     = ({1'b0, pretrigger} > (n_eff - ONE)) ? (n_eff - ONE) : {1'b0, pretrigger};
        post_init = n_eff - p_eff - ONE;
    end

    assign start_ok = start && !abort && (state == IDLE || state == DONE);
    assign trig_any = triggered || force_trigger || auto_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A trigger with a concurrent sample writes it as the first post sample, unless no post samples remain.
    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    next_state = (p_eff == '0) ? ARMED : PRE_FILL;
                end
            end
            PRE_FILL: begin
                if (input_rdy) begin
                    do_write = 1'b1;
                    if (pre_cnt + ONE == p_lat) begin
                        next_state = ARMED;
                    end
                end
            end
            ARMED: begin
                if (trig_any) begin
                    do_write = input_rdy && (post_lat != '0);
                    if (post_lat == '0 || (do_write && post_lat == ONE)) begin
                        next_state = DONE;
                    end else begin
                        next_state = POST_FILL;
                    end
                end else begin
                    do_write = input_rdy;
                end
            end
            POST_FILL: begin
                if (input_rdy) begin
                    do_write = 1'b1;
                    if (post_cnt == ONE) begin
                        next_state = DONE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
            do_write   = 1'b0;
        end
    end

    // Outputs lag the deciding edge by one clock to line up with the sample register delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_rst   <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            next_addr <= '0;
            p_lat     <= '0;
            post_lat  <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
        end else begin
            wr_en   <= do_write;
            det_rst <= (next_state != ARMED);
            busy    <= (next_state == PRE_FILL) || (next_state == ARMED) || (next_state == POST_FILL);
            done    <= (next_state == DONE) && !do_write;
            if (start_ok) begin
                p_lat     <= p_eff;
                post_lat  <= post_init;
                pre_cnt   <= '0;
                next_addr <= '0;
                wr_addr   <= '0;
            end else if (do_write) begin
                wr_addr   <= next_addr;
                next_addr <= next_addr + 1'b1;
            end
            if (state == PRE_FILL && do_write) begin
                pre_cnt <= pre_cnt + ONE;
            end
            if (state == ARMED && trig_any && !abort) begin
                trig_addr <= wr_addr;
                post_cnt  <= do_write ? (post_lat - ONE) : post_lat;
            end else if (state == POST_FILL && do_write) begin
                post_cnt <= post_cnt - ONE;
            end
        end
    end

`ifdef AUTO_TRIGGER_EN
    logic [TIMEOUT_BITS-1:0] arm_cnt;

    assign auto_hit = (state == ARMED) && (auto_timeout != '0) && (arm_cnt == auto_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt    <= '0;
            auto_fired <= 1'b0;
        end else begin
            arm_cnt <= (state == ARMED) ? (arm_cnt + 1'b1) : '0;
            if (start_ok) begin
                auto_fired <= 1'b0;
            end else if (state == ARMED && trig_any && !abort) begin
                auto_fired <= !triggered && !force_trigger;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^auto_timeout;
    assign auto_hit       = 1'b0;
    assign auto_fired     = 1'b0;
`endif

endmodule
